rns2bin_mrc: RTL and testbench

//   Residue-number-system to binary converter for a 4-modulus RNS.

---
 rtl/rns2bin_mrc.sv | 85 ++++++++
 tb/tb_rns2bin_mrc.sv | 103 ++++++++++
 2 files changed

// File: rtl/rns2bin_mrc.sv
// Four-modulus RNS to binary converter: combinational mixed-radix conversion
// with run-time moduli, followed by a single output register.
module rns2bin_mrc #(
  parameter int unsigned MOD_SIZE = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [MOD_SIZE:0]   mod_1,
  input  logic [MOD_SIZE:0]   mod_2,
  input  logic [MOD_SIZE:0]   mod_3,
  input  logic [MOD_SIZE:0]   mod_4,
  input  logic [MOD_SIZE-1:0] c0,
  input  logic [MOD_SIZE-1:0] c1,
  input  logic [MOD_SIZE-1:0] c2,
  input  logic [MOD_SIZE-1:0] c3,
  output logic [4*MOD_SIZE-1:0] n
);

  localparam int unsigned MOD_NUM = 4;
  localparam int unsigned RANGE   = MOD_NUM * MOD_SIZE;
  localparam int unsigned MW      = MOD_SIZE + 1;
  localparam int unsigned IW      = 16;

  // x mod m, with a zero modulus mapped to zero instead of an undefined divide
  function automatic logic [IW-1:0] mod_f(input logic [IW-1:0] x, input logic [MW-1:0] m);
    return (m == '0) ? '0 : (x % IW'(m));
  endfunction

  // Smallest k in 1..m-1 with a*k == 1 (mod m); zero when no inverse exists
  function automatic logic [MW-1:0] inv_f(input logic [MW-1:0] a, input logic [MW-1:0] m);
    logic [MW-1:0] res;
    res = '0;
    if (m >= MW'(2)) begin
      for (int k = 15; k >= 1; k--) begin
        if (k < int'(m) && ((IW'(a) * IW'(k)) % IW'(m)) == IW'(1)) res = MW'(k);
      end
    end
    return res;
  endfunction

  // (x - y) mod m kept non-negative by adding m before subtracting
  function automatic logic [IW-1:0] sub_f(input logic [IW-1:0] x, input logic [IW-1:0] y,
                                          input logic [MW-1:0] m);
    return mod_f(mod_f(x, m) + IW'(m) - mod_f(y, m), m);
  endfunction

  function automatic logic [IW-1:0] mul_f(input logic [IW-1:0] x, input logic [MW-1:0] k,
                                          input logic [MW-1:0] m);
    return mod_f(x * IW'(k), m);
  endfunction

  logic [IW-1:0] w_r1, w_r2, w_r3, w_r4;
  logic [IW-1:0] w_a1, w_a2, w_a3, w_a4;
  logic [IW-1:0] w_t3, w_t4a, w_t4b;
  logic [IW-1:0] w_x;

  assign w_r1 = mod_f(IW'(c0), mod_1);
  assign w_r2 = mod_f(IW'(c1), mod_2);
  assign w_r3 = mod_f(IW'(c2), mod_3);
  assign w_r4 = mod_f(IW'(c3), mod_4);

  // Mixed-radix digits, each reduced into 0..Mi-1
  assign w_a1  = w_r1;
  assign w_a2  = mul_f(sub_f(w_r2, w_a1, mod_2), inv_f(mod_1, mod_2), mod_2);
  assign w_t3  = mul_f(sub_f(w_r3, w_a1, mod_3), inv_f(mod_1, mod_3), mod_3);
  assign w_a3  = mul_f(sub_f(w_t3, w_a2, mod_3), inv_f(mod_2, mod_3), mod_3);
  assign w_t4a = mul_f(sub_f(w_r4, w_a1, mod_4), inv_f(mod_1, mod_4), mod_4);
  assign w_t4b = mul_f(sub_f(w_t4a, w_a2, mod_4), inv_f(mod_2, mod_4), mod_4);
  assign w_a4  = mul_f(sub_f(w_t4b, w_a3, mod_4), inv_f(mod_3, mod_4), mod_4);

  assign w_x = w_a1
             + w_a2 * IW'(mod_1)
             + w_a3 * IW'(mod_1) * IW'(mod_2)
             + w_a4 * IW'(mod_1) * IW'(mod_2) * IW'(mod_3);

  logic [RANGE-1:0] r_n;

  always_ff @(posedge clk) begin
    if (reset) r_n <= '0;
    else       r_n <= RANGE'(w_x);
  end

  assign n = r_n;

endmodule

// File: tb/tb_rns2bin_mrc.sv
// Directed self-checking bench for rns2bin_mrc: reset, known vectors,
// run-time moduli change and a full-range sweep with a mid-sweep reset.
module tb_rns2bin_mrc;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mod_1, mod_2, mod_3, mod_4;
  logic [2:0]  c0, c1, c2, c3;
  logic [11:0] n;

  int checks   = 0;
  int failures = 0;

  rns2bin_mrc dut (
    .clk(clk), .reset(reset),
    .mod_1(mod_1), .mod_2(mod_2), .mod_3(mod_3), .mod_4(mod_4),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3),
    .n(n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int m1, input int m2, input int m3, input int m4,
                       input int r1, input int r2, input int r3, input int r4);
    mod_1 = 4'(m1); mod_2 = 4'(m2); mod_3 = 4'(m3); mod_4 = 4'(m4);
    c0 = 3'(r1); c1 = 3'(r2); c2 = 3'(r3); c3 = 3'(r4);
  endtask

  initial begin
    logic [11:0] exp_q;
    logic        have_q;

    // Inputs change on the falling edge; outputs are checked on the falling edge
    @(negedge clk);
    reset = 1'b1;
    drive(8, 7, 5, 3, 3, 6, 4, 2);
    @(negedge clk);
    check("reset", n, 12'd0);

    reset = 1'b0;
    drive(8, 7, 5, 3, 3, 6, 4, 2);
    @(negedge clk);
    check("vec_419", n, 12'd419);
    drive(8, 7, 5, 3, 5, 1, 1, 1);
    @(negedge clk);
    check("vec_421_b2b", n, 12'd421);
    drive(8, 7, 5, 3, 0, 0, 0, 0);
    @(negedge clk);
    check("vec_zero", n, 12'd0);
    drive(8, 7, 5, 3, 7, 6, 4, 2);
    @(negedge clk);
    check("vec_max_839", n, 12'd839);
    // 57 = 1 mod 7, 2 mod 5, 0 mod 3, 1 mod 2
    drive(7, 5, 3, 2, 1, 2, 0, 1);
    @(negedge clk);
    check("vec_mod7532", n, 12'd57);
    // 209 = 6 mod 7, 4 mod 5, 2 mod 3, 1 mod 2
    drive(7, 5, 3, 2, 6, 4, 2, 1);
    @(negedge clk);
    check("vec_mod7532_max", n, 12'd209);
    // Unreduced residue: c1=6 with M2=5 acts as 1; X=1 mod 7,5, 0 mod 3, 1 mod 2 -> 141
    drive(7, 5, 3, 2, 1, 6, 0, 1);
    @(negedge clk);
    check("vec_unreduced", n, 12'd141);

    // Full sweep for M=(8,7,5,3), pipelined one vector per cycle
    have_q = 1'b0;
    exp_q  = '0;
    for (int x = 0; x <= 840; x++) begin
      if (have_q) check($sformatf("sweep_%0d", x - 1), n, exp_q);
      if (x < 840) begin
        reset = (x == 400);
        drive(8, 7, 5, 3, x % 8, x % 7, x % 5, x % 3);
        exp_q  = (x == 400) ? 12'd0 : 12'(x);
        have_q = 1'b1;
        @(negedge clk);
      end
    end
    reset = 1'b0;

    // Output resumes right after reset deasserts
    reset = 1'b1;
    drive(8, 7, 5, 3, 3, 6, 4, 2);
    @(negedge clk);
    check("reset_mid", n, 12'd0);
    reset = 1'b0;
    drive(8, 7, 5, 3, 5, 1, 1, 1);
    @(negedge clk);
    check("post_reset_421", n, 12'd421);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
